// File: rtl/bitcol_weight_encoder_16.sv
// Bit-column weight encoder/sequencer for the 16-lane vertical bit-serial MAC.
// Walks the 8 weight columns LSB->MSB and emits mux selects, skip-zero flags and MAC control.
module bitcol_weight_encoder_16 #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 16,
  parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_w_valid,
  output logic                                          o_w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]         i_w_data,
  input  logic                                          i_w_acc_clear,
  output logic [VEC_LENGTH/2-1:0][MUX_SEL_WIDTH-2:0]    o_act_sel,
  output logic [MUX_SEL_WIDTH-1:0]                      o_hamming_sel,
  output logic                                          o_hamming_sign,
  output logic                                          o_is_shift_mul,
  output logic [2:0]                                    o_mul_const,
  output logic [2:0]                                    o_column_idx,
  output logic                                          o_is_msb,
  output logic [1:0]                                    o_is_skip_zero,
  output logic                                          o_mac_en,
  output logic                                          o_mac_reset,
  output logic                                          o_done
);

  localparam int SEL_W = MUX_SEL_WIDTH - 1;
  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(VEC_LENGTH / 2);

  typedef enum logic [2:0] {PRIME, CLR, IDLE, PRE_CLR, COL, FLUSH, DONE} state_t;

  state_t r_state, w_state_nxt;
  logic [2:0] r_col, w_col_nxt;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_w_data;

  logic [VEC_LENGTH/2-1:0][SEL_W-1:0] r_act_sel, w_act_nxt;
  logic       r_w_ready, w_ready_nxt;
  logic       r_mac_reset, w_mac_reset_nxt;
  logic       r_mac_en, w_mac_en_nxt;
  logic [1:0] r_skip, w_skip_nxt;
  logic [2:0] r_col_idx, w_col_idx_nxt;
  logic       r_msb, w_msb_nxt;
  logic       r_done, w_done_nxt;

  // Column info waits here one cycle so it lines up behind the MAC's activation register.
  logic       r_pend_valid, w_pend_valid_nxt;
  logic [1:0] r_pend_skip, w_pend_skip_nxt;
  logic [2:0] r_pend_col, w_pend_col_nxt;
  logic       r_pend_msb, w_pend_msb_nxt;
  logic       r_pend_done, w_pend_done_nxt;

  logic w_accept, w_load, w_emit;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_enc_data;
  logic [2:0] w_enc_col;
  logic [1:0][7:0] w_col_bits;
  logic [1:0][4*SEL_W:0] w_enc;

  // Returns {skip_zero, 4 slots}: ones if the column is sparse, otherwise the (<=3) zeros.
  function automatic logic [4*SEL_W:0] encGroup(input logic [7:0] colBits);
    logic [7:0] sel;
    logic       skip;
    logic [2:0] k;
    logic [3:0][SEL_W-1:0] slots;
    skip  = ($countones(colBits) <= 4);
    sel   = skip ? colBits : ~colBits;
    slots = {4{SEL_ZERO}};
    k     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i] && (k < 3'd4)) begin
        slots[k[1:0]] = SEL_W'(i);
        k = k + 3'd1;
      end
    end
    return {skip, slots};
  endfunction

  assign w_accept   = (r_state == IDLE) && r_w_ready && i_w_valid;
  assign w_enc_data = w_accept ? i_w_data : r_w_data;
  assign w_enc_col  = w_accept ? 3'd0 : r_col;

  always_comb begin
    w_col_bits = '0;
    for (int g = 0; g < 2; g++) begin
      for (int j = 0; j < 8; j++) begin
        w_col_bits[g][j] = w_enc_data[g*8+j][w_enc_col];
      end
    end
    for (int g = 0; g < 2; g++) begin
      w_enc[g] = encGroup(w_col_bits[g]);
    end
  end

  // The state names the phase whose outputs are registered on the coming edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_col_nxt        = r_col;
    w_load           = 1'b0;
    w_emit           = 1'b0;
    w_act_nxt        = {(VEC_LENGTH/2){SEL_ZERO}};
    w_ready_nxt      = 1'b0;
    w_mac_reset_nxt  = 1'b0;
    w_mac_en_nxt     = r_pend_valid;
    w_skip_nxt       = r_pend_skip;
    w_col_idx_nxt    = r_pend_col;
    w_msb_nxt        = r_pend_msb;
    w_done_nxt       = r_pend_done;
    w_pend_valid_nxt = 1'b0;
    w_pend_skip_nxt  = 2'b00;
    w_pend_col_nxt   = 3'd0;
    w_pend_msb_nxt   = 1'b0;
    w_pend_done_nxt  = 1'b0;

    case (r_state)
      PRIME: begin
        w_mac_en_nxt  = 1'b1;
        w_skip_nxt    = 2'b11;
        w_col_idx_nxt = 3'd0;
        w_msb_nxt     = 1'b0;
        w_done_nxt    = 1'b0;
        w_state_nxt   = CLR;
      end
      CLR: begin
        w_mac_reset_nxt = 1'b1;
        w_state_nxt     = IDLE;
      end
      IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (i_w_acc_clear) begin
            w_mac_reset_nxt = 1'b1;
            w_col_nxt       = 3'd0;
            w_state_nxt     = PRE_CLR;
          end else begin
            w_emit      = 1'b1;
            w_col_nxt   = 3'd1;
            w_state_nxt = COL;
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      PRE_CLR: begin
        w_emit      = 1'b1;
        w_col_nxt   = 3'd1;
        w_state_nxt = COL;
      end
      COL: begin
        w_emit = 1'b1;
        if (r_col == 3'd7) begin
          w_col_nxt   = 3'd0;
          w_state_nxt = FLUSH;
        end else begin
          w_col_nxt = r_col + 3'd1;
        end
      end
      FLUSH: begin
        w_pend_valid_nxt = 1'b1;
        w_pend_skip_nxt  = 2'b11;
        w_state_nxt      = DONE;
      end
      DONE: begin
        w_pend_done_nxt = 1'b1;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = PRIME;
    endcase

    if (w_emit) begin
      w_act_nxt        = {w_enc[1][4*SEL_W-1:0], w_enc[0][4*SEL_W-1:0]};
      w_pend_valid_nxt = 1'b1;
      w_pend_skip_nxt  = {w_enc[1][4*SEL_W], w_enc[0][4*SEL_W]};
      w_pend_col_nxt   = w_enc_col;
      w_pend_msb_nxt   = (w_enc_col == 3'd7);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= PRIME;
      r_col        <= 3'd0;
      r_w_data     <= '0;
      r_act_sel    <= {(VEC_LENGTH/2){SEL_ZERO}};
      r_w_ready    <= 1'b0;
      r_mac_reset  <= 1'b0;
      r_mac_en     <= 1'b0;
      r_skip       <= 2'b00;
      r_col_idx    <= 3'd0;
      r_msb        <= 1'b0;
      r_done       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_skip  <= 2'b00;
      r_pend_col   <= 3'd0;
      r_pend_msb   <= 1'b0;
      r_pend_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      if (w_load) r_w_data <= i_w_data;
      r_act_sel    <= w_act_nxt;
      r_w_ready    <= w_ready_nxt;
      r_mac_reset  <= w_mac_reset_nxt;
      r_mac_en     <= w_mac_en_nxt;
      r_skip       <= w_skip_nxt;
      r_col_idx    <= w_col_idx_nxt;
      r_msb        <= w_msb_nxt;
      r_done       <= w_done_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_skip  <= w_pend_skip_nxt;
      r_pend_col   <= w_pend_col_nxt;
      r_pend_msb   <= w_pend_msb_nxt;
      r_pend_done  <= w_pend_done_nxt;
    end
  end

  assign o_w_ready      = r_w_ready;
  assign o_act_sel      = r_act_sel;
  assign o_hamming_sel  = MUX_SEL_WIDTH'(VEC_LENGTH);
  assign o_hamming_sign = 1'b0;
  assign o_is_shift_mul = 1'b0;
  assign o_mul_const    = 3'd0;
  assign o_column_idx   = r_col_idx;
  assign o_is_msb       = r_msb;
  assign o_is_skip_zero = r_skip;
  assign o_mac_en       = r_mac_en;
  assign o_mac_reset    = r_mac_reset;
  assign o_done         = r_done;

endmodule

// File: tb/tb_bitcol_weight_encoder_16.sv
// Directed testbench for bitcol_weight_encoder_16 with hand-computed expectations
// and a small MAC model (all activations 1, per-group sum_act 8).
module tb_bitcol_weight_encoder_16;

  logic             i_clk;
  logic             i_reset;
  logic             i_w_valid;
  logic             o_w_ready;
  logic [15:0][7:0] i_w_data;
  logic             i_w_acc_clear;
  logic [7:0][3:0]  o_act_sel;
  logic [4:0]       o_hamming_sel;
  logic             o_hamming_sign;
  logic             o_is_shift_mul;
  logic [2:0]       o_mul_const;
  logic [2:0]       o_column_idx;
  logic             o_is_msb;
  logic [1:0]       o_is_skip_zero;
  logic             o_mac_en;
  logic             o_mac_reset;
  logic             o_done;

  bitcol_weight_encoder_16 dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_w_valid      (i_w_valid),
    .o_w_ready      (o_w_ready),
    .i_w_data       (i_w_data),
    .i_w_acc_clear  (i_w_acc_clear),
    .o_act_sel      (o_act_sel),
    .o_hamming_sel  (o_hamming_sel),
    .o_hamming_sign (o_hamming_sign),
    .o_is_shift_mul (o_is_shift_mul),
    .o_mul_const    (o_mul_const),
    .o_column_idx   (o_column_idx),
    .o_is_msb       (o_is_msb),
    .o_is_skip_zero (o_is_skip_zero),
    .o_mac_en       (o_mac_en),
    .o_mac_reset    (o_mac_reset),
    .o_done         (o_done)
  );

  localparam logic [31:0] ACT_IDLE = 32'h8888_8888;

  int numVectors = 0;
  int numMiscompares = 0;
  int macAcc = 0;
  logic [31:0] prevAct;

  logic [31:0] actLog  [0:11];
  logic [1:0]  skipLog [0:11];
  logic [2:0]  colLog  [0:11];
  logic        msbLog  [0:11];
  logic        enLog   [0:11];
  logic        rstLog  [0:11];
  logic        doneLog [0:11];
  logic        rdyLog  [0:11];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // MAC golden model: act_sel is consumed one cycle after it is driven.
  function automatic int macTerm(input logic [31:0] act, input logic [1:0] skip,
                                 input logic [2:0] col, input logic msb);
    int colSum;
    int selCnt;
    colSum = 0;
    for (int g = 0; g < 2; g++) begin
      selCnt = 0;
      for (int s = 0; s < 4; s++) begin
        if (act[(4*g+s)*4 +: 4] != 4'd8) selCnt++;
      end
      colSum += skip[g] ? selCnt : (8 - selCnt);
    end
    colSum = colSum << col;
    return msb ? -colSum : colSum;
  endfunction

  always @(negedge i_clk) begin
    if (i_reset) begin
      macAcc  <= 0;
      prevAct <= ACT_IDLE;
    end else begin
      if (o_mac_reset) macAcc <= 0;
      else if (o_mac_en) macAcc <= macAcc + macTerm(prevAct, o_is_skip_zero, o_column_idx, o_is_msb);
      prevAct <= o_act_sel;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numVectors++;
    if (observed !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offers a vector and returns at the first negedge after the accepting edge.
  task automatic applyStimulus(input logic [127:0] data, input logic clear, input bit keepValid);
    int waitCnt;
    i_w_data      = data;
    i_w_acc_clear = clear;
    i_w_valid     = 1'b1;
    waitCnt       = 0;
    while (!o_w_ready && waitCnt < 40) begin
      @(negedge i_clk);
      waitCnt++;
    end
    if (!o_w_ready) begin
      checkOutput("readyTimeout", 32'(o_w_ready), 32'd1);
      i_w_valid = 1'b0;
      return;
    end
    @(negedge i_clk);
    if (!keepValid) begin
      i_w_valid     = 1'b0;
      i_w_data      = ~data;
      i_w_acc_clear = 1'b0;
    end
  endtask

  task automatic captureCycles();
    for (int i = 0; i < 12; i++) begin
      actLog[i]  = o_act_sel;
      skipLog[i] = o_is_skip_zero;
      colLog[i]  = o_column_idx;
      msbLog[i]  = o_is_msb;
      enLog[i]   = o_mac_en;
      rstLog[i]  = o_mac_reset;
      doneLog[i] = o_done;
      rdyLog[i]  = o_w_ready;
      @(negedge i_clk);
    end
  endtask

  initial begin
    i_reset       = 1'b1;
    i_w_valid     = 1'b0;
    i_w_data      = '0;
    i_w_acc_clear = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rstIdleReady", 32'(o_w_ready), 32'd0);
    checkOutput("rstIdleAct", o_act_sel, ACT_IDLE);
    checkOutput("rstIdleHam", 32'(o_hamming_sel), 32'd16);
    checkOutput("rstIdleMacEn", 32'(o_mac_en), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("primeMacEn", 32'(o_mac_en), 32'd1);
    checkOutput("primeAct", o_act_sel, ACT_IDLE);
    checkOutput("primeSkip", 32'(o_is_skip_zero), 32'd3);
    checkOutput("primeMacRst", 32'(o_mac_reset), 32'd0);
    @(negedge i_clk);
    checkOutput("clrMacRst", 32'(o_mac_reset), 32'd1);
    checkOutput("clrMacEn", 32'(o_mac_en), 32'd0);
    @(negedge i_clk);
    checkOutput("idleReady", 32'(o_w_ready), 32'd1);
    checkOutput("idleFlags", {26'd0, o_mac_en, o_mac_reset, o_done, o_is_msb, o_is_skip_zero}, 32'd0);
    checkOutput("idleColIdx", 32'(o_column_idx), 32'd0);
    checkOutput("idleHeld", {24'd0, o_hamming_sel, o_mul_const}, {24'd0, 5'd16, 3'd0});
    checkOutput("idleSigns", {30'd0, o_hamming_sign, o_is_shift_mul}, 32'd0);

    // All weights 0x01, no clear.
    applyStimulus({16{8'h01}}, 1'b0, 1'b0);
    captureCycles();
    checkOutput("ones.c0.act", actLog[0], ACT_IDLE);
    checkOutput("ones.c0.en", 32'(enLog[0]), 32'd0);
    checkOutput("ones.c0.rdy", 32'(rdyLog[0]), 32'd0);
    checkOutput("ones.c1.skip", 32'(skipLog[1]), 32'd0);
    checkOutput("ones.c1.col", 32'(colLog[1]), 32'd0);
    checkOutput("ones.c1.en", 32'(enLog[1]), 32'd1);
    checkOutput("ones.c2.skip", 32'(skipLog[2]), 32'd3);
    checkOutput("ones.c8.skip", 32'(skipLog[8]), 32'd3);
    checkOutput("ones.c8.msb", 32'(msbLog[8]), 32'd1);
    checkOutput("ones.c8.col", 32'(colLog[8]), 32'd7);
    checkOutput("ones.c7.msb", 32'(msbLog[7]), 32'd0);
    checkOutput("ones.c9.en", 32'(enLog[9]), 32'd1);
    checkOutput("ones.c9.skip", 32'(skipLog[9]), 32'd3);
    checkOutput("ones.c9.msb", 32'(msbLog[9]), 32'd0);
    checkOutput("ones.c9.done", 32'(doneLog[9]), 32'd0);
    checkOutput("ones.c10.done", 32'(doneLog[10]), 32'd1);
    checkOutput("ones.c10.en", 32'(enLog[10]), 32'd0);
    checkOutput("ones.c10.rdy", 32'(rdyLog[10]), 32'd1);
    checkOutput("ones.c11.done", 32'(doneLog[11]), 32'd0);
    checkOutput("ones.mac", 32'(macAcc), 32'd16);

    // Lanes 0..3 = 0x01: sparse column, lanes listed in slots 0..3.
    applyStimulus({96'h0, 32'h0101_0101}, 1'b0, 1'b0);
    captureCycles();
    checkOutput("low4.c0.act", actLog[0], 32'h8888_3210);
    checkOutput("low4.c1.skip", 32'(skipLog[1]), 32'd3);
    checkOutput("low4.c1.act", actLog[1], ACT_IDLE);

    // Lanes 8..15 = 0x55: dense group 1 on even columns.
    applyStimulus({{8{8'h55}}, 64'h0}, 1'b0, 1'b0);
    captureCycles();
    checkOutput("p55.c0.act", actLog[0], ACT_IDLE);
    checkOutput("p55.c1.skip", 32'(skipLog[1]), 32'd1);
    checkOutput("p55.c2.skip", 32'(skipLog[2]), 32'd3);
    checkOutput("p55.c3.skip", 32'(skipLog[3]), 32'd1);

    // Lanes 8..12 = 0x0F, 13..15 = 0: n=5, zero lanes 13,14,15 listed.
    applyStimulus({24'h0, 40'h0F_0F0F_0F0F, 64'h0}, 1'b0, 1'b0);
    captureCycles();
    checkOutput("n5.c0.act", actLog[0], 32'h8765_8888);
    checkOutput("n5.c1.skip", 32'(skipLog[1]), 32'd1);
    checkOutput("n5.c3.act", actLog[3], 32'h8765_8888);
    checkOutput("n5.c4.act", actLog[4], ACT_IDLE);
    checkOutput("n5.c5.skip", 32'(skipLog[5]), 32'd3);

    // All 0xFF with accumulator clear: index 0 is the PRE_CLR cycle.
    applyStimulus({16{8'hFF}}, 1'b1, 1'b0);
    captureCycles();
    checkOutput("ff.pre.macRst", 32'(rstLog[0]), 32'd1);
    checkOutput("ff.pre.en", 32'(enLog[0]), 32'd0);
    checkOutput("ff.pre.act", actLog[0], ACT_IDLE);
    checkOutput("ff.c0.macRst", 32'(rstLog[1]), 32'd0);
    checkOutput("ff.c1.skip", 32'(skipLog[2]), 32'd0);
    checkOutput("ff.c5.skip", 32'(skipLog[6]), 32'd0);
    checkOutput("ff.c8.skip", 32'(skipLog[9]), 32'd0);
    checkOutput("ff.c8.msb", 32'(msbLog[9]), 32'd1);
    checkOutput("ff.c8.col", 32'(colLog[9]), 32'd7);
    checkOutput("ff.c9.en", 32'(enLog[10]), 32'd1);
    checkOutput("ff.c9.skip", 32'(skipLog[10]), 32'd3);
    checkOutput("ff.c10.done", 32'(doneLog[11]), 32'd1);
    checkOutput("ff.mac", 32'(macAcc), 32'hFFFF_FFF0);

    // Reset in COL cycle 4 while w_valid stays high.
    applyStimulus({96'h0, 32'h0101_0101}, 1'b0, 1'b1);
    checkOutput("rmid.c0.act", o_act_sel, 32'h8888_3210);
    repeat (4) @(negedge i_clk);
    checkOutput("rmid.c4.en", 32'(o_mac_en), 32'd1);
    checkOutput("rmid.c4.col", 32'(o_column_idx), 32'd3);
    i_reset = 1'b1;
    @(negedge i_clk);
    checkOutput("rmid.idle.en", 32'(o_mac_en), 32'd0);
    checkOutput("rmid.idle.act", o_act_sel, ACT_IDLE);
    checkOutput("rmid.idle.rdy", 32'(o_w_ready), 32'd0);
    checkOutput("rmid.idle.col", 32'(o_column_idx), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("rmid.prime.en", 32'(o_mac_en), 32'd1);
    checkOutput("rmid.prime.rdy", 32'(o_w_ready), 32'd0);
    @(negedge i_clk);
    checkOutput("rmid.clr.macRst", 32'(o_mac_reset), 32'd1);
    checkOutput("rmid.clr.rdy", 32'(o_w_ready), 32'd0);
    @(negedge i_clk);
    checkOutput("rmid.ready", 32'(o_w_ready), 32'd1);
    @(negedge i_clk);
    checkOutput("rmid.reacc.act", o_act_sel, 32'h8888_3210);
    i_w_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    checkOutput("rmid.done", 32'(o_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule

// File: doc/bitcol_weight_encoder_16.md
# bitcol_weight_encoder_16

Bit-column weight encoder and sequencer that drives the 16-lane vertical bit-serial MAC unit. It accepts one vector of 16 signed 8-bit weights over a valid/ready handshake. It then walks the 8 bit columns LSB→MSB, emitting per column the activation-mux selects, skip-zero flags, column index and MSB flag, cycle-aligned to the MAC's one-stage activation register. It also owns MAC accumulator priming, clearing and the completion pulse.

## Interface
- DATA_WIDTH, 8, weight bit width; equals the number of columns walked.
- VEC_LENGTH, 16, weights per vector; fixed at 2 groups of 8 lanes.
- MUX_SEL_WIDTH, $clog2(VEC_LENGTH)+1, width of hamming_sel; act_sel is MUX_SEL_WIDTH-1 bits.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- w_valid  in  1  weight vector valid.
- w_ready  out  1  encoder can accept a vector.
- w_data  in  DATA_WIDTH x VEC_LENGTH  signed weights, lane i = w_data[i].
- w_acc_clear  in  1  sampled with w_data; clear the MAC accumulator before this vector.
- act_sel  out  (MUX_SEL_WIDTH-1) x VEC_LENGTH/2  mux selects; slots 4g..4g+3 belong to group g; code 0..7 = lane 8g+code, code 8 = zero.
- hamming_sel  out  MUX_SEL_WIDTH  held at 16 (zero input).
- hamming_sign, is_shift_mul  out  1  held 0.
- mul_const  out  3  held 0.
- column_idx  out  3  current column.
- is_msb  out  1  column 7 flag.
- is_skip_zero  out  1 x 2  per-group mode.
- mac_en  out  1  MAC pipeline enable.
- mac_reset  out  1  MAC accumulator clear pulse.
- done  out  1  one-cycle pulse; MAC result is final.

## Operation
- FSM states: PRIME, CLR, IDLE, PRE_CLR, COL, FLUSH, DONE.
- Reset forces PRIME.
- PRIME: one cycle with mac_en=1 and zero-contribution fields. This loads the MAC partial-sum registers with 0.
- CLR: one cycle with mac_reset=1.
- IDLE: w_ready=1.
- Handshake: a vector is accepted on the edge where w_valid&w_ready. The encoder registers w_data and w_acc_clear. Next state is PRE_CLR if w_acc_clear, else COL.
- PRE_CLR: one cycle, mac_reset=1, act_sel idle; then COL.
- COL: col counter 0..7, one cycle each; then FLUSH, then DONE, then IDLE.
- Per column c, per group g: n = popcount of bit c over lanes 8g..8g+7.
- If n≤4: is_skip_zero[g]=1. act_sel slots are filled with the indices of lanes whose bit is 1, ascending, padded with 8.
- If n≥5: is_skip_zero[g]=0. Slots are filled with the indices of lanes whose bit is 0 (at most 3), ascending, padded with 8. The MAC computes sum_act − selected.
- is_msb=1 only for c=7; column_idx=c.
- Zero-contribution fields: all act_sel=8, is_skip_zero={1,1}, is_msb=0, column_idx=0, special-PE fields at their held values.
- Idle output values (also the reset values): act_sel all 8, hamming_sel=16, all other outputs 0, w_ready=0.
- Reset mid-operation: all outputs take idle values on the next cycle and the vector is discarded. PRIME and CLR then rerun.
- sum_act is not driven by this block. The activation path supplies it.

## Timing
- All outputs are registered.
- Cycle 0 is the first COL cycle; PRE_CLR, if taken, occupies the cycle before it.
- act_sel for column c is driven in cycle c (c=0..7).
- is_skip_zero, column_idx and is_msb for column c are driven in cycle c+1, one cycle after the act_sel they pair with.
- mac_en=1 in cycles 1..9.
  - Cycles 1..8 carry columns 0..7.
  - Cycle 9 is FLUSH with zero-contribution fields; it adds the column-7 partial into the MAC result.
- done=1 in cycle 10.
- w_ready=1 from cycle 10 onward, while in IDLE.
- Back-to-back throughput: 11 cycles per vector, 12 with clear.
- After reset: PRIME in cycle R+1, CLR in R+2, first w_ready in R+3.
- w_data changes while w_ready=0 are ignored.

## Test plan
- Reset release → PRIME (mac_en=1, act_sel all 8), then CLR (mac_reset=1), then w_ready=1 with all other outputs 0 and hamming_sel=16.
- All weights 0x01, no clear.
  - Cycle 0: act_sel all 8.
  - Cycle 1: is_skip_zero={0,0}, column_idx=0.
  - Cycles 2..8: is_skip_zero={1,1}.
  - done in cycle 10.
- Lanes 0..3=0x01, others 0 → cycle 0: act_sel[0..3]=0,1,2,3 and act_sel[4..7]=8; cycle 1: is_skip_zero={1,1}.
- Lanes 8..15=0x55, group 0 = 0, bit 0 lanes all 1 in group 1 (n=8) → column 0: group 1 skip=0, slots all 8. Mixed 0x0F on lanes 8..12 with 0x00 on 13..15 (n=5) → group 1 slots 13,14,15,8.
- All weights 0xFF with w_acc_clear=1 → PRE_CLR mac_reset pulse, then every column skip=0. Cycle 8 has is_msb=1, column_idx=7. A MAC golden model with acts all 1 and sum_act=8 gives result −16.
- Reset asserted in cycle 4 of COL with w_valid held high → next cycle idle outputs, mac_en=0; PRIME/CLR sequence rerun; the vector is re-accepted only after w_ready returns.
